// File: rtl/usb_rx_sequencer.sv
// Full-speed USB receive sequencer: bit timing recovery, SYNC/NRZI/stuffing
// decode, EOP framing and bus reset detection on the 48 MHz clock.
module usb_rx_sequencer #(
  parameter int RESET_CYCLES = 120
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       dp_i,
  input  logic       dn_i,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_error,
  output logic       bus_reset
);

  localparam logic [1:0] SYM_SE0 = 2'b00;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_SE1 = 2'b11;
  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] RST_MAX = CW'(RESET_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    WAIT_IDLE
  } state_t;

  state_t        state_q;
  logic [1:0]    sym;
  logic [1:0]    sym_q;
  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] se0_cnt_q, se0_cnt_d;
  logic          rst_hit;
  logic          sample;
  logic [2:0]    sync_idx_q;
  logic [1:0]    sync_exp;
  logic [1:0]    prev_q;
  logic [2:0]    ones_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic [7:0]    byte_nxt;
  logic          nrzi_bit;
  logic          eop_step_q;
  logic          active_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          eop_q;
  logic          err_q;
  logic          bus_reset_q;

  assign sym      = {dp_i, dn_i};
  assign phase_d  = (sym != sym_q) ? 2'd0 : phase_q + 2'd1;
  assign sample   = (phase_d == 2'd2);
  assign nrzi_bit = (sym == prev_q);
  assign byte_nxt = {nrzi_bit, shift_q[7:1]};
  assign sync_exp = (sync_idx_q == 3'd7) ? SYM_K
                  : (sync_idx_q[0] ? SYM_J : SYM_K);

  always_comb begin
    se0_cnt_d = '0;
    if (sym == SYM_SE0) begin
      se0_cnt_d = (se0_cnt_q == RST_MAX) ? se0_cnt_q
                                         : se0_cnt_q + 1'b1;
    end
  end

  assign rst_hit = (se0_cnt_d == RST_MAX);

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sym_q       <= SYM_SE0;
      phase_q     <= 2'd0;
      se0_cnt_q   <= '0;
      sync_idx_q  <= 3'd0;
      prev_q      <= SYM_K;
      ones_q      <= 3'd0;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      eop_step_q  <= 1'b0;
      active_q    <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
      bus_reset_q <= 1'b0;
    end else begin
      sym_q       <= sym;
      phase_q     <= phase_d;
      se0_cnt_q   <= se0_cnt_d;
      bus_reset_q <= rst_hit;
      valid_q     <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
      if (!enable) begin
        state_q  <= IDLE;
        active_q <= 1'b0;
      end else if (rst_hit) begin
        // an open packet is aborted exactly once by the bus reset
        state_q  <= IDLE;
        active_q <= 1'b0;
        err_q    <= active_q;
      end else if (sample) begin
        unique case (state_q)
          IDLE: begin
            if (sym == SYM_K) begin
              state_q    <= SYNC;
              sync_idx_q <= 3'd1;
            end
          end
          SYNC: begin
            if (sym != sync_exp) begin
              state_q <= WAIT_IDLE;
            end else if (sync_idx_q == 3'd7) begin
              state_q  <= DATA;
              active_q <= 1'b1;
              prev_q   <= SYM_K;
              ones_q   <= 3'd0;
              bitcnt_q <= 3'd0;
            end else begin
              sync_idx_q <= sync_idx_q + 3'd1;
            end
          end
          DATA: begin
            if (sym == SYM_SE0) begin
              state_q    <= EOP;
              eop_step_q <= 1'b0;
            end else if (sym == SYM_SE1) begin
              state_q  <= WAIT_IDLE;
              active_q <= 1'b0;
              err_q    <= 1'b1;
            end else begin
              prev_q <= sym;
              if (ones_q == 3'd6) begin
                if (nrzi_bit) begin
                  state_q  <= WAIT_IDLE;
                  active_q <= 1'b0;
                  err_q    <= 1'b1;
                end else begin
                  ones_q <= 3'd0;
                end
              end else begin
                shift_q  <= byte_nxt;
                ones_q   <= nrzi_bit ? ones_q + 3'd1 : 3'd0;
                bitcnt_q <= bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                  data_q  <= byte_nxt;
                  valid_q <= 1'b1;
                end
              end
            end
          end
          EOP: begin
            if (!eop_step_q && sym == SYM_SE0) begin
              eop_step_q <= 1'b1;
            end else if (eop_step_q && sym == SYM_J) begin
              state_q  <= IDLE;
              active_q <= 1'b0;
              eop_q    <= (bitcnt_q == 3'd0);
              err_q    <= (bitcnt_q != 3'd0);
            end else begin
              state_q  <= WAIT_IDLE;
              active_q <= 1'b0;
              err_q    <= 1'b1;
            end
          end
          WAIT_IDLE: begin
            if (sym == SYM_J) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_active = active_q;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_eop    = eop_q;
  assign rx_error  = err_q;
  assign bus_reset = bus_reset_q;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Directed bench for usb_rx_sequencer: NRZI/stuffed packets, framing errors,
// bus reset, enable and async reset, with hand-derived expected timing.
module tb_usb_rx_sequencer;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk48 = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       dp_i;
  logic       dn_i;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_eop;
  logic       rx_error;
  logic       bus_reset;

  usb_rx_sequencer #(.RESET_CYCLES(120)) dut (
    .clk48     (clk48),
    .rst_n     (rst_n),
    .enable    (enable),
    .dp_i      (dp_i),
    .dn_i      (dn_i),
    .rx_active (rx_active),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_eop    (rx_eop),
    .rx_error  (rx_error),
    .bus_reset (bus_reset)
  );

  always #5 clk48 = ~clk48;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk48) cyc <= cyc + 1;

  int n_valid = 0, n_eop = 0, n_err = 0, n_rise = 0, n_multi = 0;
  int valid_cyc = 0, eop_cyc = 0, err_cyc = 0;
  int rise_cyc = 0, fall_cyc = 0, br_rise = 0, br_fall = 0;
  logic [7:0] vdata [0:63];
  logic act_d = 1'b0;
  logic br_d = 1'b0;

  always @(negedge clk48) begin
    if (rst_n) begin
      if (rx_valid) begin
        vdata[n_valid[5:0]] <= rx_data;
        n_valid <= n_valid + 1;
        valid_cyc <= cyc;
      end
      if (rx_eop) begin
        n_eop <= n_eop + 1;
        eop_cyc <= cyc;
      end
      if (rx_error) begin
        n_err <= n_err + 1;
        err_cyc <= cyc;
      end
      if ((int'(rx_valid) + int'(rx_eop) + int'(rx_error)) > 1)
        n_multi <= n_multi + 1;
      if (rx_active && !act_d) begin
        n_rise <= n_rise + 1;
        rise_cyc <= cyc;
      end
      if (!rx_active && act_d) fall_cyc <= cyc;
      if (bus_reset && !br_d) br_rise <= cyc;
      if (!bus_reset && br_d) br_fall <= cyc;
      act_d <= rx_active;
      br_d <= bus_reset;
    end
  end

  logic [1:0] cur;
  int ones;
  int last_samp, sync_samp, byte_samp, eop_samp;
  logic [1:0] sync_seq [0:7];

  // one symbol = 4 clocks; the DUT samples on the 3rd clock of each window
  task automatic send_sym(input logic [1:0] s);
    {dp_i, dn_i} = s;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk48);
      #1;
      if (i == 2) last_samp = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_sym(J);
    cur = J;
  endtask

  task automatic send_bit(input logic b);
    if (!b) cur = (cur == J) ? K : J;
    send_sym(cur);
  endtask

  task automatic send_sync();
    sync_seq = '{K, J, K, J, K, J, K, K};
    for (int i = 0; i < 8; i++) send_sym(sync_seq[i]);
    sync_samp = last_samp;
    cur = K;
    ones = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (i == 7) byte_samp = last_samp;
      if (b[i]) ones++;
      else ones = 0;
      if (ones == 6) begin
        send_bit(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    send_sym(SE0);
    send_sym(SE0);
    send_sym(J);
    eop_samp = last_samp;
    cur = J;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    {dp_i, dn_i} = J;
    cur = J;
    #12;
    checks++;
    if ({rx_active, rx_valid, rx_eop, rx_error, bus_reset, rx_data} !== 13'h0) begin
      $display("FAIL reset_outputs got act=%b v=%b e=%b err=%b br=%b data=%h want all 0",
               rx_active, rx_valid, rx_eop, rx_error, bus_reset, rx_data);
      errors++;
    end
    @(negedge clk48);
    rst_n = 1'b1;
    @(posedge clk48);
    #1;
    idle(3);
    checks++;
    if ({rx_active, rx_valid, rx_eop, rx_error, bus_reset} !== 5'b0) begin
      $display("FAIL idle_after_reset got %b want 00000",
               {rx_active, rx_valid, rx_eop, rx_error, bus_reset});
      errors++;
    end
  endtask

  task automatic test_basic_packet();
    int v0, e0, r0;
    v0 = n_valid; e0 = n_eop; r0 = n_err;
    idle(2);
    send_sync();
    send_byte(8'h69);
    send_eop();
    idle(1);
    checks++;
    if (rise_cyc !== sync_samp) begin
      $display("FAIL basic_active_rise got cyc %0d want %0d", rise_cyc, sync_samp);
      errors++;
    end
    checks++;
    if (n_valid - v0 !== 1) begin
      $display("FAIL basic_valid_count got %0d want 1", n_valid - v0);
      errors++;
    end
    checks++;
    if (vdata[v0[5:0]] !== 8'h69) begin
      $display("FAIL basic_data got %h want 69", vdata[v0[5:0]]);
      errors++;
    end
    checks++;
    if (valid_cyc !== byte_samp) begin
      $display("FAIL basic_valid_time got %0d want %0d", valid_cyc, byte_samp);
      errors++;
    end
    checks++;
    if (n_eop - e0 !== 1 || eop_cyc !== eop_samp) begin
      $display("FAIL basic_eop got n=%0d cyc=%0d want n=1 cyc=%0d",
               n_eop - e0, eop_cyc, eop_samp);
      errors++;
    end
    checks++;
    if (fall_cyc !== eop_samp) begin
      $display("FAIL basic_active_fall got %0d want %0d", fall_cyc, eop_samp);
      errors++;
    end
    checks++;
    if (n_err - r0 !== 0 || rx_data !== 8'h69) begin
      $display("FAIL basic_err_hold got err=%0d data=%h want err=0 data=69",
               n_err - r0, rx_data);
      errors++;
    end
  endtask

  task automatic test_stuffing();
    int v0, e0, r0;
    v0 = n_valid; e0 = n_eop; r0 = n_err;
    idle(2);
    send_sync();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_eop();
    idle(1);
    checks++;
    if (n_valid - v0 !== 2) begin
      $display("FAIL stuff_valid_count got %0d want 2", n_valid - v0);
      errors++;
    end
    checks++;
    if (vdata[v0[5:0]] !== 8'hFF || vdata[6'(v0 + 1)] !== 8'hFF) begin
      $display("FAIL stuff_data got %h %h want ff ff",
               vdata[v0[5:0]], vdata[6'(v0 + 1)]);
      errors++;
    end
    checks++;
    if (n_eop - e0 !== 1 || n_err - r0 !== 0) begin
      $display("FAIL stuff_eop got eop=%0d err=%0d want 1 0", n_eop - e0, n_err - r0);
      errors++;
    end
  endtask

  task automatic test_stuff_error();
    int v0, e0, r0, s7;
    v0 = n_valid; e0 = n_eop; r0 = n_err;
    idle(2);
    send_sync();
    for (int i = 0; i < 7; i++) send_sym(K);
    s7 = last_samp;
    checks++;
    if (n_err - r0 !== 1 || err_cyc !== s7) begin
      $display("FAIL stufferr_error got n=%0d cyc=%0d want n=1 cyc=%0d",
               n_err - r0, err_cyc, s7);
      errors++;
    end
    checks++;
    if (n_valid - v0 !== 0 || rx_active !== 1'b0 || fall_cyc !== s7) begin
      $display("FAIL stufferr_state got v=%0d act=%b fall=%0d want 0 0 %0d",
               n_valid - v0, rx_active, fall_cyc, s7);
      errors++;
    end
    idle(2);
    v0 = n_valid;
    send_sync();
    send_byte(8'h00);
    send_eop();
    idle(1);
    checks++;
    if (n_valid - v0 !== 1 || vdata[v0[5:0]] !== 8'h00 || n_eop - e0 !== 1) begin
      $display("FAIL stufferr_recover got v=%0d data=%h eop=%0d want 1 00 1",
               n_valid - v0, vdata[v0[5:0]], n_eop - e0);
      errors++;
    end
  endtask

  task automatic test_short_packet();
    int v0, e0, r0;
    v0 = n_valid; e0 = n_eop; r0 = n_err;
    idle(2);
    send_sync();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_eop();
    idle(1);
    checks++;
    if (n_err - r0 !== 1 || err_cyc !== eop_samp) begin
      $display("FAIL short_error got n=%0d cyc=%0d want n=1 cyc=%0d",
               n_err - r0, err_cyc, eop_samp);
      errors++;
    end
    checks++;
    if (n_eop - e0 !== 0 || n_valid - v0 !== 0) begin
      $display("FAIL short_no_eop got eop=%0d v=%0d want 0 0",
               n_eop - e0, n_valid - v0);
      errors++;
    end
  endtask

  task automatic test_bus_reset();
    int e0, r0, c0;
    e0 = n_eop; r0 = n_err;
    idle(2);
    send_sync();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    c0 = cyc;
    {dp_i, dn_i} = SE0;
    repeat (125) begin @(posedge clk48); #1; end
    checks++;
    if (bus_reset !== 1'b1 || rx_active !== 1'b0) begin
      $display("FAIL busrst_level got br=%b act=%b want 1 0", bus_reset, rx_active);
      errors++;
    end
    repeat (5) begin @(posedge clk48); #1; end
    {dp_i, dn_i} = J;
    repeat (4) begin @(posedge clk48); #1; end
    idle(2);
    checks++;
    if (br_rise !== c0 + 120) begin
      $display("FAIL busrst_rise got %0d want %0d", br_rise, c0 + 120);
      errors++;
    end
    checks++;
    if (br_fall !== c0 + 131) begin
      $display("FAIL busrst_fall got %0d want %0d", br_fall, c0 + 131);
      errors++;
    end
    checks++;
    if (n_err - r0 !== 1 || err_cyc !== c0 + 11 || n_eop - e0 !== 0) begin
      $display("FAIL busrst_error got n=%0d cyc=%0d eop=%0d want 1 %0d 0",
               n_err - r0, err_cyc, n_eop - e0, c0 + 11);
      errors++;
    end
  endtask

  task automatic test_enable();
    int v0, r0;
    logic [7:0] d0;
    v0 = n_valid; r0 = n_err;
    idle(2);
    send_sync();
    send_bit(1'b1);
    send_bit(1'b0);
    d0 = rx_data;
    enable = 1'b0;
    send_sym(cur);
    checks++;
    if (rx_active !== 1'b0) begin
      $display("FAIL enable_active got %b want 0", rx_active);
      errors++;
    end
    enable = 1'b1;
    idle(3);
    checks++;
    if (n_err - r0 !== 0 || n_valid - v0 !== 0 || rx_data !== d0) begin
      $display("FAIL enable_quiet got err=%0d v=%0d data=%h want 0 0 %h",
               n_err - r0, n_valid - v0, rx_data, d0);
      errors++;
    end
  endtask

  task automatic test_corrupt_sync();
    int v0, e0, r0, a0;
    logic [1:0] bad [0:7];
    v0 = n_valid; e0 = n_eop; r0 = n_err; a0 = n_rise;
    bad = '{K, J, K, K, J, K, K, K};
    idle(2);
    for (int i = 0; i < 8; i++) send_sym(bad[i]);
    idle(2);
    checks++;
    if (n_rise - a0 !== 0 || n_valid - v0 !== 0 || n_eop - e0 !== 0 || n_err - r0 !== 0) begin
      $display("FAIL badsync_quiet got rise=%0d v=%0d eop=%0d err=%0d want 0 0 0 0",
               n_rise - a0, n_valid - v0, n_eop - e0, n_err - r0);
      errors++;
    end
    send_sync();
    send_byte(8'h2D);
    send_eop();
    idle(1);
    checks++;
    if (n_valid - v0 !== 1 || vdata[v0[5:0]] !== 8'h2D || n_eop - e0 !== 1) begin
      $display("FAIL badsync_recover got v=%0d data=%h eop=%0d want 1 2d 1",
               n_valid - v0, vdata[v0[5:0]], n_eop - e0);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    int v0, e0, r0;
    idle(2);
    send_sync();
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (rx_active !== 1'b1) begin
      $display("FAIL arst_pre_active got %b want 1", rx_active);
      errors++;
    end
    v0 = n_valid; e0 = n_eop; r0 = n_err;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rx_active !== 1'b0 || rx_data !== 8'h00) begin
      $display("FAIL arst_clear got act=%b data=%h want 0 00", rx_active, rx_data);
      errors++;
    end
    repeat (2) @(posedge clk48);
    @(negedge clk48);
    rst_n = 1'b1;
    @(posedge clk48);
    #1;
    idle(3);
    checks++;
    if (n_valid - v0 !== 0 || n_eop - e0 !== 0 || n_err - r0 !== 0) begin
      $display("FAIL arst_no_strobe got v=%0d eop=%0d err=%0d want 0 0 0",
               n_valid - v0, n_eop - e0, n_err - r0);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_stuffing();
    test_stuff_error();
    test_short_packet();
    test_bus_reset();
    test_enable();
    test_corrupt_sync();
    test_async_reset();
    checks++;
    if (n_multi !== 0) begin
      $display("FAIL strobe_exclusive got %0d overlapping cycles want 0", n_multi);
      errors++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
